// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream stage: occupancy states and default widths.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_COUNT_WIDTH = 16;

endpackage

// File: rtl/fifo_read_stage.sv
// Drains a first-word-fall-through FIFO read port into a registered valid/ready stream via a
// 2-entry (head + skid) buffer. Optional delivered-word counter: FIFO_READ_STAGE_STATS_EN.
module fifo_read_stage
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   read_clock,
    input  logic                   read_reset_n,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    input  logic                   fifo_read_empty,
    output logic                   fifo_read_enable,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef FIFO_READ_STAGE_STATS_EN
    output logic [COUNT_WIDTH-1:0] word_count,
`endif
    output logic [1:0]             occupancy
);

    // Handshake: a stream word transfers at a rising edge where out_valid and out_ready are both 1;
    // out_valid never depends on out_ready, and data/valid hold while valid is up and ready is low.
    occ_e                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  valid_q, valid_d;
    logic                  pop;
    logic                  consume;

    // Pop strobe uses only registered occupancy, so out_ready never reaches the FIFO combinationally.
    assign fifo_read_enable = read_reset_n & ~fifo_read_empty & (occ_q != OCC_FULL);
    assign pop              = fifo_read_enable & ~fifo_read_empty;
    assign consume          = valid_q & out_ready;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (pop) begin
                    head_d = fifo_read_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (pop && !consume) begin
                    skid_d = fifo_read_data;
                    occ_d  = OCC_FULL;
                end else if (pop && consume) begin
                    head_d = fifo_read_data;
                end else if (consume) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (consume) begin
                    head_d = skid_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
        valid_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = head_q;
    assign out_valid = valid_q;
    assign occupancy = occ_q;

`ifdef FIFO_READ_STAGE_STATS_EN
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (consume) begin
            word_count_d = word_count_q + 1'b1;
        end
    end

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`else
    if (COUNT_WIDTH < 1) begin : g_bad_count_width
        $error("COUNT_WIDTH must be at least 1");
    end
`endif

endmodule

// File: tb/tb_fifo_read_stage.sv
// Bench for fifo_read_stage: a queue models the FIFO, a second queue holds words popped but not yet
// delivered; occupancy, valid, data and pop strobe are all predicted from those queues.
module tb_fifo_read_stage;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          read_clock;
    logic          read_reset_n;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_read_empty;
    logic          fifo_read_enable;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    occupancy;
`ifdef FIFO_READ_STAGE_STATS_EN
    logic [CW-1:0] word_count;
`endif

    fifo_read_stage #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .read_clock      (read_clock),
        .read_reset_n    (read_reset_n),
        .fifo_read_data  (fifo_read_data),
        .fifo_read_empty (fifo_read_empty),
        .fifo_read_enable(fifo_read_enable),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
`ifdef FIFO_READ_STAGE_STATS_EN
        .word_count      (word_count),
`endif
        .occupancy       (occupancy)
    );

    // clock / reset
    initial read_clock = 1'b0;
    always #5 read_clock = ~read_clock;

    // models and scoreboard
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] src_q[$];
    logic [CW-1:0] cnt_model;
    logic          force_empty;
    int            pops;
    int            checks;
    int            errors;

    task automatic drive_inputs();
        fifo_read_empty = (fifo_q.size() == 0) || force_empty;
        fifo_read_data  = fifo_read_empty ? DW'($urandom) : fifo_q[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        src_q.push_back(w);
    endtask

    // One clock: drive, check current outputs against the model, advance the model past the edge.
    task automatic cycle();
        logic exp_en;
        logic cons;
        drive_inputs();
        #1;
        exp_en = read_reset_n && !fifo_read_empty && (exp_q.size() < 2);
        checks++;
        if (fifo_read_enable !== exp_en) begin
            errors++;
            $display("FAIL read_enable: got %b expected %b (t=%0t)", fifo_read_enable, exp_en, $time);
        end
        checks++;
        if (occupancy !== 2'(exp_q.size())) begin
            errors++;
            $display("FAIL occupancy: got %0d expected %0d (t=%0t)", occupancy, exp_q.size(), $time);
        end
        checks++;
        if (out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b (t=%0t)", out_valid, exp_q.size() != 0, $time);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if (out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL out_data: got %h expected %h (t=%0t)", out_data, exp_q[0], $time);
            end
        end
        if (!read_reset_n) begin
            checks++;
            if (out_data !== '0) begin
                errors++;
                $display("FAIL reset_data: got %h expected 0 (t=%0t)", out_data, $time);
            end
        end
`ifdef FIFO_READ_STAGE_STATS_EN
        checks++;
        if (word_count !== cnt_model) begin
            errors++;
            $display("FAIL word_count: got %0d expected %0d (t=%0t)", word_count, cnt_model, $time);
        end
`endif
        cons = (exp_q.size() != 0) && out_ready && read_reset_n;
        @(posedge read_clock);
        #1;
        if (cons) begin
            got_q.push_back(exp_q.pop_front());
            cnt_model = cnt_model + 1'b1;
        end
        if (exp_en) begin
            exp_q.push_back(fifo_q.pop_front());
            pops++;
        end
    endtask

    task automatic drain(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (got_q.size() < target && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (got_q.size() < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, got_q.size(), target);
        end
    endtask

    task automatic async_reset();
        #2;
        read_reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || fifo_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b occ=%0d data=%h en=%b expected 0 0 00 0",
                     out_valid, occupancy, out_data, fifo_read_enable);
        end
        exp_q.delete();
        fifo_q.delete();
        src_q.delete();
        got_q.delete();
        cnt_model = '0;
    endtask

    task automatic test_reset();
        read_reset_n = 1'b0;
        out_ready    = 1'b1;
        force_empty  = 1'b0;
        push_word(8'hEE);
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (pops != 0) begin
            errors++;
            $display("FAIL reset_pops: got %0d expected 0", pops);
        end
        fifo_q.delete();
        src_q.delete();
        read_reset_n = 1'b1;
    endtask

    task automatic test_streaming();
        int n;
        got_q.delete();
        for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < 8 && n < 30) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL stream_cycles: got %0d expected 9", n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL stream_order[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, 8'h11 + 8'(i));
            end
        end
`ifdef FIFO_READ_STAGE_STATS_EN
        checks++;
        if (word_count !== 4'd8) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 8", word_count);
        end
`endif
        src_q.delete();
    endtask

    task automatic test_backpressure();
        got_q.delete();
        for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
        out_ready = 1'b0;
        pops      = 0;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (pops != 2 || occupancy !== 2'd2 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL bp_hold: pops=%0d occ=%0d data=%h expected 2 2 a0", pops, occupancy, out_data);
        end
        out_ready = 1'b1;
        drain(5, 20, "bp");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL bp_order[%0d]: expected %h", i, 8'hA0 + 8'(i));
            end
        end
        src_q.delete();
    endtask

    task automatic test_bursty_empty();
        got_q.delete();
        for (int i = 0; i < 12; i++) push_word(DW'($urandom));
        out_ready = 1'b1;
        for (int n = 0; n < 60 && got_q.size() < 12; n++) begin
            force_empty = n[0];
            cycle();
        end
        force_empty = 1'b0;
        drain(12, 10, "bursty");
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== src_q[i]) begin
                errors++;
                $display("FAIL bursty_order[%0d]: expected %h", i, src_q[i]);
            end
        end
        src_q.delete();
    endtask

    task automatic test_mid_reset();
        got_q.delete();
        push_word(8'h33);
        push_word(8'h44);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (occupancy !== 2'd2 || out_data !== 8'h33) begin
            errors++;
            $display("FAIL midrst_fill: occ=%0d data=%h expected 2 33", occupancy, out_data);
        end
        async_reset();
        push_word(8'h66);
        for (int i = 0; i < 2; i++) cycle();
        fifo_q.delete();
        src_q.delete();
        read_reset_n = 1'b1;
        push_word(8'h55);
        out_ready = 1'b1;
        drain(1, 10, "midrst");
        checks++;
        if (got_q.size() == 0 || got_q[0] !== 8'h55) begin
            errors++;
            $display("FAIL midrst_first: got %h expected 55", (got_q.size() != 0) ? got_q[0] : 8'hxx);
        end
        src_q.delete();
    endtask

    task automatic test_random();
        got_q.delete();
        for (int n = 0; n < 400; n++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push_word(DW'($urandom));
            out_ready   = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
            cycle();
        end
        force_empty = 1'b0;
        out_ready   = 1'b1;
        drain(src_q.size(), 40, "random");
        checks++;
        if (got_q.size() != src_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d expected %0d", got_q.size(), src_q.size());
        end
        for (int i = 0; i < got_q.size() && i < src_q.size(); i++) begin
            if (got_q[i] !== src_q[i]) begin
                checks++;
                errors++;
                $display("FAIL random_order[%0d]: got %h expected %h", i, got_q[i], src_q[i]);
            end
        end
        src_q.delete();
    endtask

`ifdef FIFO_READ_STAGE_STATS_EN
    task automatic test_count_wrap();
        async_reset();
        cycle();
        read_reset_n = 1'b1;
        for (int i = 0; i < 17; i++) push_word(DW'($urandom));
        out_ready = 1'b1;
        drain(17, 40, "wrap");
        checks++;
        if (word_count !== 4'd1) begin
            errors++;
            $display("FAIL count_wrap: got %0d expected 1", word_count);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        pops         = 0;
        cnt_model    = '0;
        force_empty  = 1'b0;
        read_reset_n = 1'b0;
        out_ready    = 1'b0;
        fifo_read_empty = 1'b1;
        fifo_read_data  = '0;
        @(posedge read_clock);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bursty_empty();
        test_mid_reset();
        test_random();
`ifdef FIFO_READ_STAGE_STATS_EN
        test_count_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
